// File: rtl/decoder_pipe.sv
// Registered one-hot decoder with valid/ready handshake, programmable enable mask
// and a modulo transfer counter. One transfer per cycle at full throughput.

module decoder_pipe_lane #(
   parameter int SEL_W = 4,
   parameter int IDX   = 0
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   input  logic             mask_bit,
   output logic             hit
);
   assign hit = en && mask_bit && (sel == SEL_W'(IDX));
endmodule

module decoder_pipe #(
   parameter int SEL_W     = 4,
   parameter int OUT_W     = 2**SEL_W,
   parameter bit HOLD_LAST = 1'b0,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             in_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_onehot,
   output logic [SEL_W-1:0] out_sel,
   output logic             out_err,
   input  logic             mask_we,
   input  logic [OUT_W-1:0] mask_wdata,
   output logic [OUT_W-1:0] mask,
   output logic [CNT_W-1:0] dec_count
);

   logic             acc;
   logic             err_nxt;
   logic [OUT_W-1:0] onehot_nxt;

   // in_ready deliberately has no path from in_valid.
   assign in_ready = !out_valid || out_ready;
   assign acc      = in_valid && in_ready;
   assign err_nxt  = in_en && !mask[in_sel];

   for (genvar i = 0; i < OUT_W; i++) begin : g_lane
      decoder_pipe_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
         .sel      (in_sel),
         .en       (in_en),
         .mask_bit (mask[i]),
         .hit      (onehot_nxt[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_onehot <= '0;
         out_sel    <= '0;
         out_err    <= 1'b0;
         mask       <= '1;
         dec_count  <= '0;
      end else begin
         if (acc) begin
            out_valid  <= 1'b1;
            out_onehot <= onehot_nxt;
            out_sel    <= in_sel;
            out_err    <= err_nxt;
            dec_count  <= dec_count + CNT_W'(1);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (!HOLD_LAST) begin
               out_onehot <= '0;
               out_err    <= 1'b0;
            end
         end
         // Same-cycle accept above already sampled the old mask.
         if (mask_we)
            mask <= mask_wdata;
      end
   end

endmodule

// File: tb/tb_decoder_pipe.sv
// Randomized bench for decoder_pipe: three instances (default, HOLD_LAST=1, SEL_W=3/CNT_W=2)
// share one stimulus stream and are compared each cycle against a transaction-level model.

module tb_decoder_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_en, out_ready, mask_we;
   logic [3:0]  in_sel;
   logic [15:0] mask_wdata;

   logic        rdy0, rdy1, rdy2;
   logic        vld0, vld1, vld2;
   logic        err0, err1, err2;
   logic [15:0] oh0, oh1, mask0, mask1, cnt0, cnt1;
   logic [3:0]  sel0, sel1;
   logic [7:0]  oh2, mask2;
   logic [2:0]  sel2;
   logic [1:0]  cnt2;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // model state per instance
   logic        m_valid [3];
   logic [15:0] m_oh    [3];
   logic [3:0]  m_sel   [3];
   logic        m_err   [3];
   logic [15:0] m_mask  [3];
   int          m_cnt   [3];

   always #5 clk = ~clk;

   decoder_pipe u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_sel(in_sel),
      .in_en(in_en), .out_valid(vld0), .out_ready(out_ready), .out_onehot(oh0),
      .out_sel(sel0), .out_err(err0), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .mask(mask0), .dec_count(cnt0)
   );

   decoder_pipe #(.HOLD_LAST(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_sel(in_sel),
      .in_en(in_en), .out_valid(vld1), .out_ready(out_ready), .out_onehot(oh1),
      .out_sel(sel1), .out_err(err1), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .mask(mask1), .dec_count(cnt1)
   );

   decoder_pipe #(.SEL_W(3), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_sel(in_sel[2:0]),
      .in_en(in_en), .out_valid(vld2), .out_ready(out_ready), .out_onehot(oh2),
      .out_sel(sel2), .out_err(err2), .mask_we(mask_we), .mask_wdata(mask_wdata[7:0]),
      .mask(mask2), .dec_count(cnt2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_valid[k] = 1'b0;
         m_oh[k]    = '0;
         m_sel[k]   = '0;
         m_err[k]   = 1'b0;
         m_mask[k]  = (k == 2) ? 16'h00ff : 16'hffff;
         m_cnt[k]   = 0;
      end
   endtask

   // One clock of the transfer rules, applied at the rising edge with the inputs then present.
   task automatic model_update();
      for (int k = 0; k < 3; k++) begin
         int  s;
         bit  hold, mbit;
         s    = (k == 2) ? int'(in_sel[2:0]) : int'(in_sel);
         hold = (k == 1);
         if (in_valid && (!m_valid[k] || out_ready)) begin
            mbit       = m_mask[k][s];
            m_sel[k]   = 4'(s);
            m_oh[k]    = (in_en && mbit) ? (16'd1 << s) : 16'd0;
            m_err[k]   = in_en && !mbit;
            m_valid[k] = 1'b1;
            m_cnt[k]   = (m_cnt[k] + 1) % ((k == 2) ? 4 : 65536);
         end else if (m_valid[k] && out_ready) begin
            m_valid[k] = 1'b0;
            if (!hold) begin
               m_oh[k]  = '0;
               m_err[k] = 1'b0;
            end
         end
         if (mask_we)
            m_mask[k] = (k == 2) ? {8'h00, mask_wdata[7:0]} : mask_wdata;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("rdy0", rdy0, !m_valid[0] || out_ready);
         chk("vld0", vld0, m_valid[0]);
         chk("oh0",  oh0,  m_oh[0]);
         chk("sel0", sel0, m_sel[0]);
         chk("err0", err0, m_err[0]);
         chk("mask0", mask0, m_mask[0]);
         chk("cnt0", cnt0, m_cnt[0]);
         chk("vld1", vld1, m_valid[1]);
         chk("oh1",  oh1,  m_oh[1]);
         chk("sel1", sel1, m_sel[1]);
         chk("err1", err1, m_err[1]);
         chk("cnt1", cnt1, m_cnt[1]);
         chk("rdy2", rdy2, !m_valid[2] || out_ready);
         chk("vld2", vld2, m_valid[2]);
         chk("oh2",  {24'h0, oh2}, {16'h0, m_oh[2]});
         chk("sel2", sel2, m_sel[2][2:0]);
         chk("err2", err2, m_err[2]);
         chk("mask2", {24'h0, mask2}, {16'h0, m_mask[2]});
         chk("cnt2", cnt2, m_cnt[2]);
      end
   end

   initial begin
      logic [15:0] c;
      rst_n = 1'b0; in_valid = 1'b0; in_en = 1'b1; out_ready = 1'b1;
      mask_we = 1'b0; in_sel = '0; mask_wdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", vld0, 1'b0);
      chk("rst_oh", oh0, 16'h0);
      chk("rst_mask", mask0, 16'hffff);
      chk("rst_cnt", cnt0, 16'h0);
      chk("rst_ready", rdy0, 1'b1);
      chk("rst_mask_small", mask2, 8'hff);
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // back-to-back sweep
      in_valid = 1'b1;
      for (int s = 0; s < 16; s++) begin
         in_sel = 4'(s);
         step();
         if (s == 0)  chk("sweep_first", oh0, 16'h0001);
         if (s == 15) chk("sweep_last", oh0, 16'h8000);
      end
      in_valid = 1'b0;
      chk("sweep_cnt", cnt0, 16'd16);
      step();

      // backpressure
      in_valid = 1'b1; in_sel = 4'd5;
      step();
      chk("bp_first", oh0, 16'h0020);
      out_ready = 1'b0; in_sel = 4'd9;
      repeat (3) begin
         step();
         chk("bp_ready", rdy0, 1'b0);
         chk("bp_hold", oh0, 16'h0020);
      end
      out_ready = 1'b1;
      step();
      chk("bp_release", oh0, 16'h0200);

      // mask write with same-cycle accept uses the old mask
      mask_we = 1'b1; mask_wdata = 16'hfff7; in_sel = 4'd3;
      step();
      mask_we = 1'b0;
      chk("mask_old", oh0, 16'h0008);
      step();
      chk("mask_new_oh", oh0, 16'h0000);
      chk("mask_new_err", err0, 1'b1);

      // disabled transfer
      in_en = 1'b0; in_sel = 4'd7; c = cnt0;
      step();
      chk("dis_oh", oh0, 16'h0000);
      chk("dis_err", err0, 1'b0);
      chk("dis_cnt", cnt0, c + 16'd1);
      in_en = 1'b1;

      // drain behaviour for both HOLD_LAST settings
      in_sel = 4'd2;
      step();
      in_valid = 1'b0;
      step();
      chk("hold_valid", vld1, 1'b0);
      chk("hold_oh", oh1, 16'h0004);
      chk("nohold_oh", oh0, 16'h0000);

      // narrow instance
      in_valid = 1'b1; in_sel = 4'd6;
      step();
      chk("small_oh", oh2, 8'h40);
      in_valid = 1'b0;
      step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_sel     = 4'($urandom_range(0, 15));
         in_en      = ($urandom_range(0, 7) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         mask_we    = ($urandom_range(0, 15) == 0);
         mask_wdata = 16'($urandom);
         step();
      end

      // async reset with a stalled transfer and a pending mask write
      in_valid = 1'b1; out_ready = 1'b0; in_sel = 4'd4; in_en = 1'b1; mask_we = 1'b0;
      step();
      in_valid = 1'b0; mask_we = 1'b1; mask_wdata = 16'h0000;
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("areset_valid", vld0, 1'b0);
      chk("areset_mask", mask0, 16'hffff);
      chk("areset_cnt", cnt0, 16'h0);
      chk("areset_ready", rdy0, 1'b1);
      mask_we = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // counter wrap on the CNT_W=2 instance
      out_ready = 1'b1; in_valid = 1'b1;
      repeat (4) begin
         in_sel = 4'($urandom_range(0, 15));
         step();
      end
      in_valid = 1'b0;
      chk("wrap_small", cnt2, 2'd0);
      chk("wrap_big", cnt0, 16'd4);
      step();
      step();

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, registered successor to the team's 4-to-16 gate-level decoder. It converts a SEL_W-bit select code into a 2^SEL_W one-hot word behind a valid/ready handshake, with a programmable enable mask, a decoder-enable input and a transfer counter. It sits between the ALU opcode source and the function-unit select lines, and it replaces the purely combinational decoder wherever backpressure or registered selects are needed.

## Interface
- SEL_W, 4, select code width; legal range 1..8.
- OUT_W, 2**SEL_W, one-hot width; derived from SEL_W, never overridden.
- HOLD_LAST, 0, 0: out_onehot is forced to zero while out_valid=0; 1: out_onehot holds the last transferred value.
- CNT_W, 16, width of the transfer counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  select code presented.
- in_ready  out  1  block can accept; in_ready = !out_valid || out_ready (combinational).
- in_sel  in  SEL_W  select code.
- in_en  in  1  decoder enable; 0 produces an all-zero one-hot.
- out_valid  out  1  output register holds a transfer.
- out_ready  in  1  downstream accepts.
- out_onehot  out  OUT_W  decoded word, registered.
- out_sel  out  SEL_W  registered copy of the accepted in_sel.
- out_err  out  1  sideband, qualified by out_valid: the accepted code was masked.
- mask_we  in  1  write enable for the mask register.
- mask_wdata  in  OUT_W  new mask value; bit i=1 enables code i.
- mask  out  OUT_W  current mask.
- dec_count  out  CNT_W  number of accepted input transfers, modulo 2^CNT_W.

## Operation
- Accept: acc = in_valid && in_ready. On acc, load the output register:
  - out_sel = in_sel
  - out_onehot = (in_en && mask[in_sel]) ? (1 << in_sel) : 0
  - out_err = in_en && !mask[in_sel]
  - out_valid = 1
- Drain: on out_valid && out_ready with no acc, clear out_valid. If HOLD_LAST=0, also clear out_onehot and out_err. If HOLD_LAST=1, keep out_onehot, out_sel and out_err.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1): the new transfer is loaded and out_valid stays 1. This is full throughput, one transfer per cycle.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and the output register is stable.
- Disabled transfer (in_en=0): the transfer still completes, out_valid=1, out_onehot=0, out_err=0, and dec_count still increments.
- Mask write: mask <= mask_wdata on the rising edge when mask_we=1. A transfer accepted in the same cycle uses the old mask.
- dec_count increments by 1 on every acc and wraps from 2^CNT_W-1 to 0.
- Exactly one bit of out_onehot is set whenever out_valid=1, in_en was 1 and the code was unmasked. Otherwise out_onehot is zero.

## Timing
- Reset (async assert, sync-safe release): out_valid=0, out_onehot=0, out_sel=0, out_err=0, mask=all ones, dec_count=0. in_ready therefore reads 1 during and after reset.
- Reset mid-operation: a pending output transfer is discarded and is not replayed. A mask write in the same cycle is lost.
- Latency: in_sel is accepted on edge N, and out_valid/out_onehot are visible after edge N; the output is presented in cycle N+1.
- in_ready is combinational from out_valid and out_ready only, with no path from in_valid.
- out_* change only on a clock edge or on reset assertion.

## Test plan
- Reset then sweep: out_ready=1, drive in_sel=0..15 back-to-back with in_en=1 → out_onehot=0x0001..0x8000 on consecutive cycles, out_err=0, dec_count=16.
- Backpressure: accept in_sel=5, then hold out_ready=0 for 3 cycles with in_valid=1, in_sel=9 → in_ready=0, out_onehot holds 0x0020. Release out_ready → next cycle out_onehot=0x0200.
- Mask: write mask=0xFFF7, same cycle accept in_sel=3 → out_onehot=0x0008 (old mask). Next accept in_sel=3 → out_onehot=0, out_err=1.
- Disable and HOLD_LAST: in_en=0, in_sel=7 → out_onehot=0, out_err=0, count increments. With HOLD_LAST=1, accept in_sel=2 then drain → out_valid=0, out_onehot stays 0x0004. With HOLD_LAST=0 → 0.
- Reset mid-transfer: out_valid=1, out_ready=0, assert rst_n=0 asynchronously between edges → immediately out_valid=0, mask=0xFFFF, dec_count=0.
- Parameter and wrap: SEL_W=3, CNT_W=2 → in_sel=6 gives 0x40. After 4 transfers dec_count=0.
